// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register.
// Captures the fetched instruction and its PC pair for decode one cycle later.
// Fetch misses, taken-branch flushes and post-HALT slots become NOP bubbles.
// A hazard stall holds the contents.
// Optional feature macro: IFID_STATS_EN enables a saturating bubble counter
// on bubble_cnt. Without the macro, bubble_cnt is constant 0.
module ifid_reg #(
    parameter logic [15:0] NOP_INSTR  = 16'h0800,
    parameter logic [15:0] HALT_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_curr_in,
    input  logic [15:0] pc_next_in,
    input  logic        fetch_stall,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] IFID_instr,
    output logic [15:0] IFID_PC_curr,
    output logic [15:0] IFID_PC_Next,
    output logic        IFID_valid,
    output logic        halt_seen,
    output logic [15:0] bubble_cnt
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t state;

    // Pipeline slot and halt FSM; priority is rst > flush > stall > fetch_stall/halted > capture
    always_ff @(posedge clk) begin
        if (rst) begin
            IFID_instr   <= NOP_INSTR;
            IFID_PC_curr <= '0;
            IFID_PC_Next <= '0;
            IFID_valid   <= 1'b0;
            halt_seen    <= 1'b0;
            state        <= RUN;
        end else if (flush) begin
            // A latched HALT sat on the wrong path, so the halt condition is squashed too
            IFID_instr <= NOP_INSTR;
            IFID_valid <= 1'b0;
            halt_seen  <= 1'b0;
            state      <= RUN;
        end else if (stall) begin
            // Hold everything, including in HALTED
        end else if (fetch_stall || state == HALTED) begin
            // After HALT has been presented for one advancing cycle, every later slot is dropped
            IFID_instr <= NOP_INSTR;
            IFID_valid <= 1'b0;
        end else begin
            IFID_instr   <= instr_in;
            IFID_PC_curr <= pc_curr_in;
            IFID_PC_Next <= pc_next_in;
            IFID_valid   <= 1'b1;
            if (instr_in == HALT_INSTR) begin
                state     <= HALTED;
                halt_seen <= 1'b1;
            end
        end
    end

`ifdef IFID_STATS_EN
    logic        bubble;
    logic [15:0] bubble_cnt_q;

    // An advancing edge that loads a NOP bubble; flush with fetch_stall counts once
    always_comb begin
        bubble = 1'b0;
        if (flush) begin
            bubble = 1'b1;
        end else if (!stall && (fetch_stall || state == HALTED)) begin
            bubble = 1'b1;
        end
    end

    // Saturating bubble counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else if (bubble && bubble_cnt_q != '1) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    assign bubble_cnt = '0;
`endif

endmodule
